// File: rtl/alu_arbiter_if.sv
// Handshake bundle between the two ALU clients, the response consumer and the
// shared ALU instance. The arbiter uses the slave view; the environment drives master.
interface alu_arbiter_if #(
    parameter int AW = 4,
    parameter int SW = 2,
    parameter int YW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_a;
    logic [AW-1:0] req0_b;
    logic [SW-1:0] req0_s;

    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_a;
    logic [AW-1:0] req1_b;
    logic [SW-1:0] req1_s;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [YW-1:0] rsp_y;
    logic          rsp_id;

    logic [AW-1:0] alu_a;
    logic [AW-1:0] alu_b;
    logic [SW-1:0] alu_s;
    logic [YW-1:0] alu_y;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s,
        input  req1_valid, req1_a, req1_b, req1_s,
        input  rsp_ready, alu_y,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_y, rsp_id,
        output alu_a, alu_b, alu_s
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_s,
        output req1_valid, req1_a, req1_b, req1_s,
        output rsp_ready, alu_y,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_y, rsp_id,
        input  alu_a, alu_b, alu_s
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// accept in IDLE, let the ALU settle in EXEC, hold the result in RESP until taken.
module alu_arbiter (
    input  logic            clk,
    input  logic            rst_n,
    alu_arbiter_if.slave    bus,
    output logic            busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state_reg;
    logic       last_grant_reg;
    logic       winner;
    logic       any_valid;
    logic       accept;

    // On contention the requester not served last wins; otherwise the lone valid wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant_reg;
        end else begin
            winner = bus.req1_valid;
        end
        accept = (state_reg == IDLE) && any_valid;
    end

    assign bus.req0_ready = accept && !winner;
    assign bus.req1_ready = accept && winner;
    assign busy           = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_s      <= '0;
            bus.rsp_y      <= '0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_valid  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bus.alu_a      <= winner ? bus.req1_a : bus.req0_a;
                        bus.alu_b      <= winner ? bus.req1_b : bus.req0_b;
                        bus.alu_s      <= winner ? bus.req1_s : bus.req0_s;
                        bus.rsp_id     <= winner;
                        last_grant_reg <= winner;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle; sample its output.
                    bus.rsp_y     <= bus.alu_y;
                    bus.rsp_valid <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a multiplying ALU stub (Y = A*B).
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    logic busy;

    alu_arbiter_if #(.AW(4), .SW(2), .YW(8)) bus ();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    assign bus.alu_y = {4'd0, bus.alu_a} * {4'd0, bus.alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for its ready, then drop valid after the accept edge.
    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        int n;
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_s = s; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_s = s; bus.req1_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!((id == 0) ? bus.req0_ready : bus.req1_ready) && n < 20) begin
            step();
            n++;
        end
        check($sformatf("issue%0d_ready", id), {31'd0, ((id == 0) ? bus.req0_ready : bus.req1_ready)}, 32'd1);
        step();
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    logic both_ready_seen;

    // Wait (bounded) for rsp_valid and check the payload; does not consume.
    task automatic wait_rsp(input string tag, input logic [7:0] exp_y, input logic exp_id);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            if (bus.req0_ready && bus.req1_ready) both_ready_seen = 1'b1;
            step();
            n++;
        end
        check({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "_y"}, {24'd0, bus.rsp_y}, {24'd0, exp_y});
        check({tag, "_id"}, {31'd0, bus.rsp_id}, {31'd0, exp_id});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    int  acc_cyc [3];
    int  n_acc;
    int  cyc;
    logic flag;

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_s = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_s = 0;
        bus.rsp_ready = 1'b1;
        both_ready_seen = 1'b0;
        step();
        step();

        // Reset state
        check("rst_alu_a", {28'd0, bus.alu_a}, 32'd0);
        check("rst_alu_s", {30'd0, bus.alu_s}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_y", {24'd0, bus.rsp_y}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single request: 3*5
        bus.req0_a = 4'd3; bus.req0_b = 4'd5; bus.req0_s = 2'd2; bus.req0_valid = 1'b1;
        #1;
        check("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
        check("single_ready1", {31'd0, bus.req1_ready}, 32'd0);
        step();
        bus.req0_valid = 1'b0;
        check("single_alu_s", {30'd0, bus.alu_s}, 32'd2);
        check("single_alu_a", {28'd0, bus.alu_a}, 32'd3);
        check("single_busy_exec", {31'd0, busy}, 32'd1);
        check("single_rsp_early", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        check("single_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("single_rsp_y", {24'd0, bus.rsp_y}, 32'd15);
        check("single_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        check("single_busy_resp", {31'd0, busy}, 32'd1);
        step();
        check("single_rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
        check("single_busy_idle", {31'd0, busy}, 32'd0);

        // Contention after reset: strict alternation starting with requester 0
        do_reset();
        both_ready_seen = 1'b0;
        bus.req0_a = 4'd2; bus.req0_b = 4'd7; bus.req0_s = 2'd0;
        bus.req1_a = 4'd4; bus.req1_b = 4'd4; bus.req1_s = 2'd1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            step();
            wait_rsp($sformatf("cont%0d", i), (i % 2 == 0) ? 8'd14 : 8'd16, (i % 2 == 1));
            if (i == 3) begin
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            end
            step();
            if (bus.req0_ready && bus.req1_ready) both_ready_seen = 1'b1;
        end
        check("cont_never_both_ready", {31'd0, both_ready_seen}, 32'd0);

        // Back-pressure: 15*15 held while both requesters knock
        bus.rsp_ready = 1'b0;
        issue(1, 4'd15, 4'd15, 2'd3);
        wait_rsp("bp", 8'hE1, 1'b1);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.rsp_valid || bus.rsp_y !== 8'hE1 || bus.rsp_id !== 1'b1 ||
                bus.req0_ready || bus.req1_ready) flag = 1'b1;
        end
        check("bp_stable", {31'd0, flag}, 32'd0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        check("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_release_busy", {31'd0, busy}, 32'd0);

        // Fairness: lone requester 1 served back to back every 3 cycles
        bus.req1_a = 4'd2; bus.req1_b = 4'd3; bus.req1_valid = 1'b1;
        #1;
        n_acc = 0; cyc = 0; flag = 1'b0;
        while (n_acc < 3 && cyc < 30) begin
            if (bus.req0_ready) flag = 1'b1;
            if (bus.req1_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            step();
            if (n_acc == 3) bus.req1_valid = 1'b0;
            cyc++;
        end
        check("fair_accepts", n_acc, 32'd3);
        check("fair_gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
        check("fair_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
        check("fair_no_ready0", {31'd0, flag}, 32'd0);
        cyc = 0;
        while (busy && cyc < 20) begin
            step();
            cyc++;
        end
        check("fair_idle", {31'd0, busy}, 32'd0);
        bus.req0_a = 4'd5; bus.req0_b = 4'd5; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check("fair_ready0_wins", {31'd0, bus.req0_ready}, 32'd1);
        check("fair_ready1_loses", {31'd0, bus.req1_ready}, 32'd0);
        step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp("fair_rsp", 8'd25, 1'b0);
        step();

        // Reset mid-operation
        issue(0, 4'd6, 4'd6, 2'd0);
        check("midrst_busy_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        flag = bus.rsp_valid;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_alu_a", {28'd0, bus.alu_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.rsp_valid) flag = 1'b1;
        end
        rst_n = 1'b1;
        #1;
        check("midrst_no_rsp", {31'd0, flag}, 32'd0);
        check("midrst_rsp_y", {24'd0, bus.rsp_y}, 32'd0);
        check("midrst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        issue(1, 4'd1, 4'd9, 2'd1);
        wait_rsp("midrst_new", 8'd9, 1'b1);
        step();

        // Requester 0 waits through a requester 1 operation with its payload held
        issue(1, 4'd3, 4'd3, 2'd0);
        bus.req0_a = 4'd9; bus.req0_b = 4'd11; bus.req0_s = 2'd3; bus.req0_valid = 1'b1;
        #1;
        check("held_not_ready_exec", {31'd0, bus.req0_ready}, 32'd0);
        wait_rsp("held_r1", 8'd9, 1'b1);
        check("held_not_ready_resp", {31'd0, bus.req0_ready}, 32'd0);
        step();
        check("held_ready_idle", {31'd0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        check("held_alu_a", {28'd0, bus.alu_a}, 32'd9);
        check("held_alu_b", {28'd0, bus.alu_b}, 32'd11);
        check("held_alu_s", {30'd0, bus.alu_s}, 32'd3);
        wait_rsp("held_r0", 8'd99, 1'b0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
